present_sbox_sched: RTL and testbench



---
 rtl/present_sbox_sched.sv | 169 ++++++++++++++++
 tb/tb_present_sbox_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/present_sbox_sched.sv
// Time-shared PRESENT S-box bank arbitrating between the data layer and key schedule.
// Optional inverse-table support for data requests: define PRESENT_SBOX_INV_EN.
module present_sbox_sched #(
  parameter int unsigned LANES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  output logic        d_done,
  input  logic        k_valid,
  output logic        k_ready,
  input  logic [3:0]  k_in,
  output logic [3:0]  k_out,
  output logic        k_done,
  output logic        busy
`ifdef PRESENT_SBOX_INV_EN
  ,
  input  logic        d_inv
`endif
);

  localparam int unsigned NBEATS = 16 / LANES;
  localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_illegal
      $error("present_sbox_sched: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DATA, KEY} state_t;
  typedef enum logic {GR_DATA, GR_KEY} grant_t;

  state_t          state_q, state_d;
  grant_t          last_q;
  logic [BW-1:0]   beat_q;
  logic [63:0]     w_q, w_sub;
  logic [3:0]      k_q;
  logic            last_beat;
  logic [3:0]      lane_in  [LANES];
  logic [3:0]      lane_out [LANES];
`ifdef PRESENT_SBOX_INV_EN
  logic            inv_q;
`endif

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

`ifdef PRESENT_SBOX_INV_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
      4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
      4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
    endcase
  endfunction
`endif

  assign busy      = (state_q != IDLE);
  assign last_beat = (beat_q == BW'(NBEATS - 1));

  // Round-robin: on contention the requester that did not win last time is granted.
  always_comb begin
    d_ready = 1'b0;
    k_ready = 1'b0;
    if (state_q == IDLE) begin
      if (d_valid && k_valid) begin
        if (last_q == GR_DATA) k_ready = 1'b1;
        else                   d_ready = 1'b1;
      end else begin
        d_ready = d_valid;
        k_ready = k_valid;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (d_ready) state_d = DATA;
               else if (k_ready) state_d = KEY;
      DATA:    if (last_beat) state_d = IDLE;
      KEY:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane 0 is borrowed by the key schedule while in KEY.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_in[i]  = w_q[(32'(beat_q) * LANES + i) * 4 +: 4];
      lane_out[i] = sbox_fwd(lane_in[i]);
`ifdef PRESENT_SBOX_INV_EN
      if (inv_q && state_q == DATA) lane_out[i] = sbox_inv(lane_in[i]);
`endif
    end
    if (state_q == KEY) begin
      lane_in[0]  = k_q;
      lane_out[0] = sbox_fwd(k_q);
    end
  end

  always_comb begin
    w_sub = w_q;
    for (int unsigned i = 0; i < LANES; i++)
      w_sub[(32'(beat_q) * LANES + i) * 4 +: 4] = lane_out[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= GR_DATA;
      beat_q  <= '0;
      w_q     <= '0;
      k_q     <= '0;
      d_out   <= '0;
      k_out   <= '0;
      d_done  <= 1'b0;
      k_done  <= 1'b0;
`ifdef PRESENT_SBOX_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      d_done  <= 1'b0;
      k_done  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_ready) begin
            w_q    <= d_in;
            beat_q <= '0;
            last_q <= GR_DATA;
`ifdef PRESENT_SBOX_INV_EN
            inv_q  <= d_inv;
`endif
          end else if (k_ready) begin
            k_q    <= k_in;
            last_q <= GR_KEY;
          end
        end
        DATA: begin
          w_q <= w_sub;
          if (last_beat) begin
            d_out  <= w_sub;
            d_done <= 1'b1;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        KEY: begin
          k_out  <= lane_out[0];
          k_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_sbox_sched.sv
// Directed self-checking bench for present_sbox_sched (LANES=4 main, LANES=1/16 latency).
module tb_present_sbox_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid, k_valid, dx_valid, kx_valid, d_inv;
  logic [63:0] d_in;
  logic [3:0]  k_in;

  logic        d_ready4, d_done4, k_ready4, k_done4, busy4;
  logic [63:0] d_out4;
  logic [3:0]  k_out4;
  logic        d_ready1, d_done1, k_ready1, k_done1, busy1;
  logic [63:0] d_out1;
  logic [3:0]  k_out1;
  logic        d_ready16, d_done16, k_ready16, k_done16, busy16;
  logic [63:0] d_out16;
  logic [3:0]  k_out16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  present_sbox_sched #(.LANES(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .d_valid(d_valid), .d_ready(d_ready4), .d_in(d_in), .d_out(d_out4), .d_done(d_done4),
    .k_valid(k_valid), .k_ready(k_ready4), .k_in(k_in), .k_out(k_out4), .k_done(k_done4),
    .busy(busy4)
`ifdef PRESENT_SBOX_INV_EN
    , .d_inv(d_inv)
`endif
  );

  present_sbox_sched #(.LANES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .d_valid(dx_valid), .d_ready(d_ready1), .d_in(d_in), .d_out(d_out1), .d_done(d_done1),
    .k_valid(kx_valid), .k_ready(k_ready1), .k_in(k_in), .k_out(k_out1), .k_done(k_done1),
    .busy(busy1)
`ifdef PRESENT_SBOX_INV_EN
    , .d_inv(d_inv)
`endif
  );

  present_sbox_sched #(.LANES(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .d_valid(dx_valid), .d_ready(d_ready16), .d_in(d_in), .d_out(d_out16), .d_done(d_done16),
    .k_valid(kx_valid), .k_ready(k_ready16), .k_in(k_in), .k_out(k_out16), .k_done(k_done16),
    .busy(busy16)
`ifdef PRESENT_SBOX_INV_EN
    , .d_inv(d_inv)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a data request on u4, wait for d_done; returns latency and busy-cycle count.
  task automatic data_req(input logic [63:0] din, output int lat, output int bcnt);
    d_in = din;
    d_valid = 1'b1;
    #1;
    chk("d_ready_on_req", 64'(d_ready4), 64'd1);
    step();
    d_valid = 1'b0;
    lat = 0;
    bcnt = busy4 ? 1 : 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (d_done4) begin
        lat = c;
        break;
      end
      if (busy4) bcnt++;
    end
  endtask

  int lat, bcnt, l1, l4, l16, seen;
  logic [63:0] o1, o4, o16;

  initial begin
    rst_n = 1'b0; d_valid = 1'b0; k_valid = 1'b0; dx_valid = 1'b0; kx_valid = 1'b0;
    d_inv = 1'b0; d_in = '0; k_in = '0;
    step(); step();
    chk("rst_d_out", d_out4, 64'd0);
    chk("rst_k_out", 64'(k_out4), 64'd0);
    chk("rst_d_done", 64'(d_done4), 64'd0);
    chk("rst_k_done", 64'(k_done4), 64'd0);
    chk("rst_busy", 64'(busy4), 64'd0);
    rst_n = 1'b1;
    step();

    // All-zero layer
    data_req(64'h0, lat, bcnt);
    chk("zero_latency", 64'(lat), 64'd4);
    chk("zero_busy_cycles", 64'(bcnt), 64'd4);
    chk("zero_d_out", d_out4, 64'hCCCCCCCCCCCCCCCC);
    step();
    chk("d_done_single_pulse", 64'(d_done4), 64'd0);

    // Same vector through LANES=4, 1, 16 together
    d_in = 64'h0123456789ABCDEF;
    d_valid = 1'b1;
    dx_valid = 1'b1;
    #1;
    chk("ready_l1", 64'(d_ready1), 64'd1);
    chk("ready_l16", 64'(d_ready16), 64'd1);
    step();
    d_valid = 1'b0;
    dx_valid = 1'b0;
    l1 = 0; l4 = 0; l16 = 0; o1 = '0; o4 = '0; o16 = '0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (d_done4 && l4 == 0) begin l4 = c; o4 = d_out4; end
      if (d_done1 && l1 == 0) begin l1 = c; o1 = d_out1; end
      if (d_done16 && l16 == 0) begin l16 = c; o16 = d_out16; end
      if (l1 != 0 && l4 != 0 && l16 != 0) break;
    end
    chk("lat_l4", 64'(l4), 64'd4);
    chk("lat_l1", 64'(l1), 64'd16);
    chk("lat_l16", 64'(l16), 64'd1);
    chk("out_l4", o4, 64'hC56B90AD3EF84712);
    chk("out_l1", o1, 64'hC56B90AD3EF84712);
    chk("out_l16", o16, 64'hC56B90AD3EF84712);
    step();

    // Key nibble
    k_in = 4'h9;
    k_valid = 1'b1;
    #1;
    chk("k_ready_on_req", 64'(k_ready4), 64'd1);
    chk("d_ready_idle_key", 64'(d_ready4), 64'd0);
    step();
    k_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (k_done4) begin lat = c; break; end
    end
    chk("key_latency", 64'(lat), 64'd1);
    chk("key_k_out", 64'(k_out4), 64'hE);
    chk("key_d_out_held", d_out4, 64'hC56B90AD3EF84712);
    step();

    // Reset during beat 2
    d_in = '1;
    d_valid = 1'b1;
    #1;
    step();
    d_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_d_out", d_out4, 64'd0);
    chk("midrst_k_out", 64'(k_out4), 64'd0);
    chk("midrst_busy", 64'(busy4), 64'd0);
    chk("midrst_d_done", 64'(d_done4), 64'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      step();
      if (d_done4) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    data_req(64'h0123456789ABCDEF, lat, bcnt);
    chk("postrst_latency", 64'(lat), 64'd4);
    chk("postrst_d_out", d_out4, 64'hC56B90AD3EF84712);
    step();

    // Contention right after reset: key, data, key
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    d_in = 64'hFEDCBA9876543210;
    k_in = 4'h3;
    d_valid = 1'b1;
    k_valid = 1'b1;
    #1;
    chk("cont1_k_ready", 64'(k_ready4), 64'd1);
    chk("cont1_d_ready", 64'(d_ready4), 64'd0);
    step();
    k_in = 4'hA;
    #1;
    chk("cont_key_busy_ready", 64'({d_ready4, k_ready4}), 64'd0);
    step();
    chk("cont_k_done", 64'(k_done4), 64'd1);
    chk("cont_k_out", 64'(k_out4), 64'hB);
    chk("cont2_d_ready", 64'(d_ready4), 64'd1);
    chk("cont2_k_ready", 64'(k_ready4), 64'd0);
    step();
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (d_done4) begin lat = c; break; end
    end
    chk("cont_d_latency", 64'(lat), 64'd4);
    chk("cont_d_out", d_out4, 64'h21748FE3DA09B65C);
    chk("cont3_k_ready", 64'(k_ready4), 64'd1);
    chk("cont3_d_ready", 64'(d_ready4), 64'd0);
    step();
    d_valid = 1'b0;
    k_valid = 1'b0;
    step();
    chk("cont3_k_done", 64'(k_done4), 64'd1);
    chk("cont3_k_out", 64'(k_out4), 64'hF);
    step();

`ifdef PRESENT_SBOX_INV_EN
    d_inv = 1'b1;
    data_req(64'hC56B90AD3EF84712, lat, bcnt);
    d_inv = 1'b0;
    chk("inv_latency", 64'(lat), 64'd4);
    chk("inv_d_out", d_out4, 64'h0123456789ABCDEF);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
